// File: rtl/apb_slave_mem_bfm_pkg.sv
// Shared types and constants for the APB3 slave memory model: FSM states,
// control-register offsets and control-field widths.
package apb_slave_mem_bfm_pkg;

  localparam int DATA_W    = 32;
  localparam int XFERCNT_W = 16;
  localparam int WAITCFG_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  localparam logic [1:0] CTRL_WAITCFG = 2'd0;
  localparam logic [1:0] CTRL_ERRADDR = 2'd1;
  localparam logic [1:0] CTRL_ERREN   = 2'd2;
  localparam logic [1:0] CTRL_XFERCNT = 2'd3;

endpackage

// File: rtl/apb_slave_mem_bfm_ram.sv
// Single-port word memory: synchronous write, asynchronous read, no reset.
module apb_slave_mem_bfm_ram
  import apb_slave_mem_bfm_pkg::*;
#(
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**AWIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/apb_slave_mem_bfm.sv
// APB3 slave memory model: programmable wait states, error injection on one
// word, transfer counter and a sticky protocol-violation flag.
module apb_slave_mem_bfm
  import apb_slave_mem_bfm_pkg::*;
#(
  parameter int MEM_AWIDTH = 8,
  parameter int TPD        = 1
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              PROTERR
);

  state_e                 state;
  logic [WAITCFG_W-1:0]   wait_cnt;
  logic [WAITCFG_W-1:0]   waitcfg;
  logic [MEM_AWIDTH-1:0]  erraddr;
  logic                   erren;
  logic [XFERCNT_W-1:0]   xfercnt;
  logic [31:0]            cap_addr;
  logic [DATA_W-1:0]      cap_wdata;
  logic                   cap_write;

  logic [31:0]            acc_addr;
  logic                   acc_write;
  logic                   acc_ctrl;
  logic [MEM_AWIDTH-1:0]  acc_word;
  logic                   err_hit;
  logic                   changed;
  logic                   ram_we;
  logic [DATA_W-1:0]      ram_rdata;
  logic [DATA_W-1:0]      ctrl_rdata;
  logic [DATA_W-1:0]      next_rdata;

  // TPD only describes simulation output timing; the RTL outputs are zero-delay.
  logic unused_tpd;
  assign unused_tpd = (TPD != 0);

  // In IDLE the setup-phase bus is decoded directly; afterwards the captured copy.
  assign acc_addr  = (state == ST_IDLE) ? PADDR  : cap_addr;
  assign acc_write = (state == ST_IDLE) ? PWRITE : cap_write;
  assign acc_ctrl  = acc_addr[MEM_AWIDTH+2];
  assign acc_word  = acc_addr[MEM_AWIDTH+1:2];
  assign err_hit   = !acc_ctrl && erren && (acc_word == erraddr);
  assign changed   = (PADDR != cap_addr) || (PWRITE != cap_write) || (PWDATA != cap_wdata);
  assign ram_we    = (state == ST_ACCESS) && PSEL && PENABLE && cap_write
                     && !cap_addr[MEM_AWIDTH+2] && !PSLVERR;
  assign PREADY    = (state != ST_WAIT);

  always_comb begin
    ctrl_rdata = '0;
    case (acc_addr[3:2])
      CTRL_WAITCFG: ctrl_rdata = DATA_W'(waitcfg);
      CTRL_ERRADDR: ctrl_rdata = DATA_W'(erraddr);
      CTRL_ERREN:   ctrl_rdata = DATA_W'(erren);
      default:      ctrl_rdata = DATA_W'(xfercnt);
    endcase
    next_rdata = (acc_write || err_hit) ? '0 : (acc_ctrl ? ctrl_rdata : ram_rdata);
  end

  apb_slave_mem_bfm_ram #(.AWIDTH(MEM_AWIDTH)) u_ram (
    .clk   (PCLK),
    .we    (ram_we),
    .addr  (acc_word),
    .wdata (cap_wdata),
    .rdata (ram_rdata)
  );

  // Setup-phase capture; data path only, so no reset.
  always_ff @(posedge PCLK) begin
    if (state == ST_IDLE && PSEL && !PENABLE) begin
      cap_addr  <= PADDR;
      cap_write <= PWRITE;
      cap_wdata <= PWDATA;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      waitcfg  <= '0;
      erraddr  <= '0;
      erren    <= 1'b0;
      xfercnt  <= '0;
      PRDATA   <= '0;
      PSLVERR  <= 1'b0;
      PROTERR  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (PSEL && PENABLE) begin
            PROTERR <= 1'b1;
          end else if (PSEL) begin
            wait_cnt <= waitcfg;
            if (waitcfg != '0) begin
              state <= ST_WAIT;
            end else begin
              state   <= ST_ACCESS;
              PRDATA  <= next_rdata;
              PSLVERR <= err_hit;
            end
          end
        end
        ST_WAIT: begin
          if (!PSEL) begin
            PROTERR <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            if (changed) PROTERR <= 1'b1;
            if (wait_cnt == WAITCFG_W'(1)) begin
              state   <= ST_ACCESS;
              PRDATA  <= next_rdata;
              PSLVERR <= err_hit;
            end else begin
              wait_cnt <= wait_cnt - WAITCFG_W'(1);
            end
          end
        end
        ST_ACCESS: begin
          if (!PSEL) begin
            PROTERR <= 1'b1;
            state   <= ST_IDLE;
            PRDATA  <= '0;
            PSLVERR <= 1'b0;
          end else begin
            if (changed) PROTERR <= 1'b1;
            if (PENABLE) begin
              state   <= ST_IDLE;
              PRDATA  <= '0;
              PSLVERR <= 1'b0;
              xfercnt <= xfercnt + XFERCNT_W'(1);
              // XFERCNT is read-only: its offset falls to the empty default.
              if (cap_write && cap_addr[MEM_AWIDTH+2]) begin
                case (cap_addr[3:2])
                  CTRL_WAITCFG: waitcfg <= cap_wdata[WAITCFG_W-1:0];
                  CTRL_ERRADDR: erraddr <= cap_wdata[MEM_AWIDTH-1:0];
                  CTRL_ERREN:   erren   <= cap_wdata[0];
                  default: ;
                endcase
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
